// File: rtl/dec_stage_if.sv
// rtl/dec_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
// Purpose: groups the inbound instruction stream and the outbound decoded bundle.
// Ports (signals):
//   in_valid/in_ready/inst/pc            - instruction offered by fetch
//   out_valid/out_ready                  - decoded bundle handshake toward execute
//   out_pc, rd, rs1, rs2, imm, alu_op,
//   op_class, mem_size, is_mem_sign,
//   mem_wbmask, mem_wen, rd_wen, illegal - registered decoded fields
// Modports: master = surrounding pipeline (fetch + execute), slave = decode stage.
interface dec_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst;
  logic [XLEN-1:0]     pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [REG_ID_W-1:0] rd;
  logic [REG_ID_W-1:0] rs1;
  logic [REG_ID_W-1:0] rs2;
  logic [XLEN-1:0]     imm;
  logic [3:0]          alu_op;
  logic [3:0]          op_class;
  logic [1:0]          mem_size;
  logic                is_mem_sign;
  logic [3:0]          mem_wbmask;
  logic                mem_wen;
  logic                rd_wen;
  logic                illegal;

  modport master (
    output in_valid, inst, pc, out_ready,
    input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op, op_class,
           mem_size, is_mem_sign, mem_wbmask, mem_wen, rd_wen, illegal
  );

  modport slave (
    input  in_valid, inst, pc, out_ready,
    output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op, op_class,
           mem_size, is_mem_sign, mem_wbmask, mem_wen, rd_wen, illegal
  );
endinterface

// File: rtl/dec_stage.sv
// rtl/dec_stage.sv - registered, handshaked RV32I decode stage
// Purpose: decodes one RV32I instruction per cycle into a registered bundle for execute.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   flush - drops the held bundle and any instruction offered this cycle
//   bus   - dec_stage_if.slave: inbound inst/pc stream and outbound decoded bundle
module dec_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  dec_stage_if.slave  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    C_NONE = 4'd0, C_IMM = 4'd1, C_REG = 4'd2, C_LOAD = 4'd3, C_STORE = 4'd4,
    C_LUI = 4'd5, C_AUIPC = 4'd6, C_JAL = 4'd7, C_JALR = 4'd8, C_BRANCH = 4'd9,
    C_FENCE = 4'd10, C_ECALL = 4'd11, C_EBREAK = 4'd12
  } op_class_e;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign inst   = bus.inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  op_class_e       d_class;
  logic            d_illegal;
  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_alu_op;
  logic [1:0]      d_mem_size;
  logic            d_mem_sign;
  logic [3:0]      d_wbmask;
  logic            d_mem_wen;
  logic            d_writes_rd;

  // Each legal case fills in its fields; anything unrecognised leaves the
  // all-zero defaults and only raises d_illegal.
  always_comb begin
    d_class     = C_NONE;
    d_illegal   = 1'b0;
    d_imm       = '0;
    d_alu_op    = 4'b0;
    d_mem_size  = 2'b0;
    d_mem_sign  = 1'b0;
    d_wbmask    = 4'b0;
    d_mem_wen   = 1'b0;
    d_writes_rd = 1'b0;
    if (inst[1:0] != 2'b11) begin
      d_illegal = 1'b1;
    end else begin
      unique case (opcode)
        OP_LUI:   begin d_class = C_LUI;   d_imm = imm_u; d_writes_rd = 1'b1; end
        OP_AUIPC: begin d_class = C_AUIPC; d_imm = imm_u; d_writes_rd = 1'b1; end
        OP_JAL:   begin d_class = C_JAL;   d_imm = imm_j; d_writes_rd = 1'b1; end
        OP_JALR: begin
          if (funct3 != 3'b000) d_illegal = 1'b1;
          else begin d_class = C_JALR; d_imm = imm_i; d_writes_rd = 1'b1; end
        end
        OP_BRANCH: begin
          if (funct3[2:1] == 2'b01) d_illegal = 1'b1;
          else begin d_class = C_BRANCH; d_imm = imm_b; d_alu_op = {1'b0, funct3}; end
        end
        OP_LOAD: begin
          // 011, 110 and 111 have no RV32I load
          if (funct3 == 3'b011 || funct3[2:1] == 2'b11) d_illegal = 1'b1;
          else begin
            d_class     = C_LOAD;
            d_imm       = imm_i;
            d_mem_size  = funct3[1:0];
            d_mem_sign  = !funct3[2];
            d_writes_rd = 1'b1;
          end
        end
        OP_STORE: begin
          if (funct3[2] || funct3[1:0] == 2'b11) d_illegal = 1'b1;
          else begin
            d_class    = C_STORE;
            d_imm      = imm_s;
            d_mem_size = funct3[1:0];
            d_mem_wen  = 1'b1;
            d_wbmask   = (funct3[1:0] == 2'b00) ? 4'b0001 :
                         (funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
          end
        end
        OP_IMM: begin
          // shift immediates carry funct7 in imm[11:5]; only SRAI may set bit 30
          if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
              (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
            d_illegal = 1'b1;
          else begin
            d_class     = C_IMM;
            d_imm       = imm_i;
            d_alu_op    = {inst[30] & (funct3 == 3'b101), funct3};
            d_writes_rd = 1'b1;
          end
        end
        OP_REG: begin
          if (funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
            d_class     = C_REG;
            d_alu_op    = {inst[30], funct3};
            d_writes_rd = 1'b1;
          end else d_illegal = 1'b1;
        end
        OP_FENCE: d_class = C_FENCE;
        OP_SYSTEM: begin
          if (inst == 32'h0000_0073)      d_class = C_ECALL;
          else if (inst == 32'h0010_0073) d_class = C_EBREAK;
          else                            d_illegal = 1'b1;
        end
        default: d_illegal = 1'b1;
      endcase
    end
  end

  logic accept;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Bundle data is only rewritten on accept, so it stays stable while stalled
  // and is left in place (not cleared) once consumed or flushed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.rd          <= '0;
      bus.rs1         <= '0;
      bus.rs2         <= '0;
      bus.imm         <= '0;
      bus.alu_op      <= 4'b0;
      bus.op_class    <= 4'b0;
      bus.mem_size    <= 2'b0;
      bus.is_mem_sign <= 1'b0;
      bus.mem_wbmask  <= 4'b0;
      bus.mem_wen     <= 1'b0;
      bus.rd_wen      <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      if (flush) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (accept) begin
        bus.out_pc      <= bus.pc;
        bus.rd          <= REG_ID_W'(inst[11:7]);
        bus.rs1         <= REG_ID_W'(inst[19:15]);
        bus.rs2         <= REG_ID_W'(inst[24:20]);
        bus.imm         <= d_imm;
        bus.alu_op      <= d_alu_op;
        bus.op_class    <= d_class;
        bus.mem_size    <= d_mem_size;
        bus.is_mem_sign <= d_mem_sign;
        bus.mem_wbmask  <= d_wbmask;
        bus.mem_wen     <= d_mem_wen;
        bus.rd_wen      <= d_writes_rd && (inst[11:7] != 5'd0);
        bus.illegal     <= d_illegal;
      end
    end
  end

endmodule

// File: tb/tb_dec_stage.sv
// tb/tb_dec_stage.sv - randomized self-checking bench for dec_stage against a reference decoder
module tb_dec_stage;

  logic clock;
  logic reset;
  logic flush;

  dec_stage_if #(.XLEN(32), .REG_ID_W(5)) bus ();

  dec_stage #(.XLEN(32), .REG_ID_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  cls;
    logic        ill;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  msz;
    logic        msign;
    logic [3:0]  mask;
    logic        mwen;
    logic        rdwen;
  } exp_t;

  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t e;
    logic signed [31:0] si;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, wr;
    int m;
    e = '0; si = i; f3 = i[14:12]; f7 = i[31:25]; ok = 1'b1; wr = 1'b0;
    imm_i = si >>> 20;
    imm_s = (imm_i & ~32'h1F) | {27'd0, i[11:7]};
    imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    imm_j = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    imm_u = i & 32'hFFFF_F000;
    case (i[6:0])
      7'h37: begin e.cls = 5; e.imm = imm_u; wr = 1; end
      7'h17: begin e.cls = 6; e.imm = imm_u; wr = 1; end
      7'h6F: begin e.cls = 7; e.imm = imm_j; wr = 1; end
      7'h67: begin ok = (f3 == 0); e.cls = 8; e.imm = imm_i; wr = 1; end
      7'h63: begin ok = (f3 != 2 && f3 != 3); e.cls = 9; e.imm = imm_b; e.alu = {1'b0, f3}; end
      7'h03: begin
        ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.cls = 3; e.imm = imm_i; e.msz = 2'(f3 % 4); e.msign = (f3 < 4); wr = 1;
      end
      7'h23: begin
        ok = (f3 < 3); e.cls = 4; e.imm = imm_s; e.mwen = 1;
        m = (1 << (1 << f3)) - 1; e.mask = m[3:0];
      end
      7'h13: begin
        ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && !(f7 inside {7'h00, 7'h20}));
        e.cls = 1; e.imm = imm_i; e.alu = {i[30] && f3 == 5, f3}; wr = 1;
      end
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.cls = 2; e.alu = {i[30], f3}; wr = 1;
      end
      7'h0F: e.cls = 10;
      7'h73: begin
        if (i == 32'h73) e.cls = 11;
        else if (i == 32'h100073) e.cls = 12;
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (i[1:0] != 2'b11) ok = 0;
    e.rdwen = wr && (i[11:7] != 0);
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 14) r[6:0] = ops[$urandom_range(0, 10)];
    if (k == 13) r[1:0] = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    if (r[6:0] == 7'h73 && $urandom_range(0, 2) != 0) r = $urandom_range(0, 1) ? 32'h73 : 32'h100073;
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Cycle-level expectation of the held bundle.
  logic        mv;
  exp_t        me;
  logic [31:0] mi;
  logic [31:0] mp;

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, mv);
    if (mv) begin
      chk("out_pc", bus.out_pc, mp);
      chk("rd", bus.rd, mi[11:7]);
      chk("rs1", bus.rs1, mi[19:15]);
      chk("rs2", bus.rs2, mi[24:20]);
      chk("op_class", bus.op_class, me.cls);
      chk("illegal", bus.illegal, me.ill);
      chk("alu_op", bus.alu_op, me.alu);
      chk("rd_wen", bus.rd_wen, me.rdwen);
      chk("mem_wen", bus.mem_wen, me.mwen);
      chk("mem_wbmask", bus.mem_wbmask, me.mask);
      if (!me.ill) chk("imm", bus.imm, me.imm);
      if (me.cls == 4'd3) begin
        chk("mem_size", bus.mem_size, me.msz);
        chk("is_mem_sign", bus.is_mem_sign, me.msign);
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic ordy, input logic fl);
    logic acc;
    @(negedge clock);
    bus.in_valid  = v;
    bus.inst      = i;
    bus.pc        = p;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    chk("in_ready", bus.in_ready, !mv || ordy);
    acc = v && (!mv || ordy) && !fl;
    @(posedge clock);
    if (fl) mv = 1'b0;
    else if (acc) begin
      mv = 1'b1; me = ref_dec(i); mi = i; mp = p;
    end else if (ordy) mv = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ov"}, bus.out_valid, 0);
    chk({tag, "_pc"}, bus.out_pc, 0);
    chk({tag, "_regs"}, {bus.rd, bus.rs1, bus.rs2}, 0);
    chk({tag, "_imm"}, bus.imm, 0);
    chk({tag, "_misc"}, {bus.alu_op, bus.op_class, bus.mem_size, bus.is_mem_sign,
                         bus.mem_wbmask, bus.mem_wen, bus.rd_wen, bus.illegal}, 0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.inst = '0; bus.pc = '0; bus.out_ready = 1'b0;
    mv = 1'b0; me = '0; mi = '0; mp = '0;
    repeat (2) @(posedge clock);
    #1 check_all_zero("reset");
    @(negedge clock) reset = 1'b1;

    // directed decode cases
    step(1, 32'hFFF08293, 32'h100, 1, 0);
    chk("addi_cls", bus.op_class, 1);  chk("addi_rd", bus.rd, 5);
    chk("addi_rs1", bus.rs1, 1);       chk("addi_imm", bus.imm, 32'hFFFF_FFFF);
    chk("addi_alu", bus.alu_op, 0);    chk("addi_wen", bus.rd_wen, 1);
    chk("addi_pc", bus.out_pc, 32'h100);
    step(1, 32'h4020D1B3, 32'h104, 1, 0);
    chk("sra_cls", bus.op_class, 2);   chk("sra_alu", bus.alu_op, 4'b1101);
    step(1, 32'h402091B3, 32'h108, 1, 0);
    chk("sub001_ill", bus.illegal, 1); chk("sub001_wen", bus.rd_wen, 0);
    step(1, 32'h00209323, 32'h10C, 1, 0);
    chk("sh_cls", bus.op_class, 4);    chk("sh_imm", bus.imm, 6);
    chk("sh_mask", bus.mem_wbmask, 4'b0011); chk("sh_wen", bus.mem_wen, 1);
    step(1, 32'h00014083, 32'h110, 1, 0);
    chk("lbu_cls", bus.op_class, 3);   chk("lbu_size", bus.mem_size, 0);
    chk("lbu_sign", bus.is_mem_sign, 0);
    step(1, 32'hFE000EE3, 32'h114, 1, 0);
    chk("beq_cls", bus.op_class, 9);   chk("beq_imm", bus.imm, 32'hFFFF_FFFC);
    chk("beq_wen", bus.rd_wen, 0);
    step(1, 32'h001000EF, 32'h118, 1, 0);
    chk("jal_cls", bus.op_class, 7);   chk("jal_imm", bus.imm, 32'h800);
    step(1, 32'h00000073, 32'h11C, 1, 0);
    chk("ecall_cls", bus.op_class, 11);
    step(1, 32'h00100073, 32'h120, 1, 0);
    chk("ebreak_cls", bus.op_class, 12);

    // stall mid-stream: first bundle held, second re-offered until taken
    step(1, 32'h00100093, 32'h200, 1, 0);
    step(1, 32'h00200113, 32'h204, 0, 0);
    chk("stall_pc", bus.out_pc, 32'h200);
    step(1, 32'h00200113, 32'h204, 0, 0);
    chk("stall_pc2", bus.out_pc, 32'h200);
    chk("stall_rd", bus.rd, 1);
    step(1, 32'h00200113, 32'h204, 1, 0);
    chk("stream2_pc", bus.out_pc, 32'h204);
    step(1, 32'h00300193, 32'h208, 1, 0);
    chk("stream3_pc", bus.out_pc, 32'h208);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("drain_ov", bus.out_valid, 0);

    // flush with a held bundle and a new offer in the same cycle
    step(1, 32'h00400213, 32'h300, 1, 0);
    step(1, 32'h00500293, 32'h304, 1, 1);
    chk("flush_ov", bus.out_valid, 0);

    // randomized traffic with occasional flush and one asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0);
      if (n == 1500) begin
        if (!mv) step(1, 32'h00A00513, 32'h400, 1, 0);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        mv = 1'b0;
        @(negedge clock) reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_stage.md
Name: dec_stage

Overview:
- Registered, handshaked RV32I decode stage between fetch and execute.
- Decodes the full RV32I base set, including branches, JAL, AUIPC, FENCE and ECALL/EBREAK, and flags illegal encodings.
- Holds one decoded instruction in an output register with valid/ready flow control and a flush input.
- Widths are parametrised.

Parameters:
- XLEN, 32, data/immediate/PC width; must be ≥32; immediates sign-extended to XLEN.
- REG_ID_W, 5, register index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  discard held and incoming instruction this cycle.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  raw instruction.
- pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_pc  out  XLEN  registered pc.
- rd, rs1, rs2  out  REG_ID_W each  register indices; zero-extended from inst fields.
- imm  out  XLEN  selected immediate.
- alu_op  out  4  {alt bit, funct3}.
- op_class  out  4  instruction class.
- mem_size  out  2  00 byte, 01 half, 10 word.
- is_mem_sign  out  1  load sign-extends.
- mem_wbmask  out  4  store byte mask.
- mem_wen  out  1  store.
- rd_wen  out  1  writes rd, and rd≠0.
- illegal  out  1  unrecognised encoding.

Behaviour:
- Reset (async assert, sync release): out_valid=0, every registered output=0.
- op_class codes: 0 NONE, 1 IMM, 2 REG, 3 LOAD, 4 STORE, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 BRANCH, 10 FENCE, 11 ECALL, 12 EBREAK.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to XLEN from inst[31].
  - REG, FENCE and ECALL/EBREAK set imm=0.
- alu_op:
  - REG: {inst[30], funct3}.
  - IMM: {inst[30] & (funct3==101), funct3}.
  - BRANCH: {0, funct3}.
  - All other classes: 0.
- Loads:
  - Legal funct3 values: 000, 001, 010, 100, 101.
  - mem_size = funct3[1:0].
  - is_mem_sign = !funct3[2].
- Stores:
  - Legal funct3 values: 000/001/010, giving wbmask 0001/0011/1111.
  - mem_wen=1.
- Illegal (op_class=NONE, illegal=1, rd_wen=0, mem_wen=0, wbmask=0) when any of:
  - unknown opcode;
  - inst[1:0]≠11;
  - reserved load/store/branch funct3 (branch 010, 011);
  - REG with inst[31:25] ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101};
  - IMM shift (funct3 001/101) with bad inst[31:25];
  - JALR funct3≠000;
  - SYSTEM other than exact ECALL 0x00000073 / EBREAK 0x00100073.
- rd_wen=1 for IMM, REG, LOAD, LUI, AUIPC, JAL, JALR, and only when rd≠0.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Accept when in_valid & in_ready & !flush: register the decoded bundle; out_valid=1 next cycle (1-cycle latency).
  - When out_valid & out_ready and there is no accept, out_valid→0.
  - While out_valid & !out_ready, all outputs hold stable.
- flush: next cycle out_valid=0. An instruction offered in the same cycle is dropped; in_ready is still driven per the formula. flush overrides accept.
- Back-to-back throughput: 1 instruction/cycle when out_ready is held high.
- Outputs are valid only when out_valid=1. Data is not cleared on consume.

Test Plan:
- addi x5,x1,-1 (0xFFF08293), pc=0x100 → next cycle: out_valid=1, op_class=1, rd=5, rs1=1, imm=0xFFFFFFFF, alu_op=0000, rd_wen=1, out_pc=0x100.
- sra x3,x1,x2 (0x4020D1B3) → op_class=2, alu_op=1101. sub with funct3=001 (0x402091B3) → illegal=1, rd_wen=0.
- sh x2,6(x1) (0x00209323) → op_class=4, imm=6, wbmask=0011, mem_wen=1. lbu x1,0(x2) (0x00014083) → op_class=3, mem_size=00, is_mem_sign=0.
- beq x0,x0,-4 (0xFE000EE3) → op_class=9, imm=0xFFFFFFFC, rd_wen=0. jal x1,2048 (0x001000EF) → op_class=7, imm=0x800.
- Stream 3 instructions with out_ready=0 for 2 cycles mid-stream → first bundle held stable, in_ready=0; no loss or duplication; order preserved.
- flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0. Reset asserted mid-stream (asynchronous) → out_valid=0 and all outputs 0 immediately.
